led_matrix_scan: RTL

Parametrised multiplexed LED-matrix driver: N_ROWS x N_COLS, generalising the fixed 8x8, 64-bit-frame scanner.
- Scans one row at a time from an internal prescaler.
- Adds per-row PWM brightness with a blanking slot, selectable drive polarity, and a double-buffered frame load handshake for tear-free updates.
- Sits between frame-producing logic (LFSR, pattern generators, CPU port) and the matrix pins.

---
 rtl/led_matrix_pkg.sv | 15 +
 rtl/scan_tick_gen.sv | 29 ++
 rtl/led_matrix_scan.sv | 119 +++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared widths and drive polarity constants for the LED matrix scanner
package led_matrix_pkg;

  localparam logic ACT_HIGH = 1'b1;
  localparam logic ACT_LOW  = 1'b0;

  function automatic int row_w(input int n_rows);
    return (n_rows > 1) ? $clog2(n_rows) : 1;
  endfunction

  function automatic int phase_w(input int pwm_bits);
    return pwm_bits;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running prescaler, one-cycle tick every DIV_CYCLES clocks
module scan_tick_gen
  import led_matrix_pkg::*;
#(
  parameter int DIV_CYCLES = 4096
) (
  input  logic i_CLK,
  input  logic i_RST,
  output logic o_Tick
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_count <= '0;
    end else if (r_count == CNT_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_Tick = (r_count == CNT_LAST);

endmodule

// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - row-multiplexed LED matrix driver with PWM brightness and double-buffered frames
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int N_ROWS       = 8,
  parameter int N_COLS       = 8,
  parameter int DIV_CYCLES   = 4096,
  parameter int PWM_BITS     = 3,
  parameter bit ROW_ACT_HIGH = 1'b1,
  parameter bit COL_ACT_HIGH = 1'b0
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_Enable,
  input  logic [PWM_BITS-1:0]      i_Brightness,
  input  logic                     i_Frame_DV,
  input  logic [N_ROWS*N_COLS-1:0] i_Frame_Data,
  output logic                     o_Frame_Ready,
  output logic                     o_Frame_Sync,
  output logic [N_ROWS-1:0]        o_Rows,
  output logic [N_COLS-1:0]        o_Columns
);

  localparam int ROW_W   = row_w(N_ROWS);
  localparam int PHASE_W = phase_w(PWM_BITS);
  localparam int FRAME_W = N_ROWS * N_COLS;
  localparam int IDX_W   = $clog2(FRAME_W);

  localparam logic ROW_ON = ROW_ACT_HIGH ? ACT_HIGH : ACT_LOW;
  localparam logic COL_ON = COL_ACT_HIGH ? ACT_HIGH : ACT_LOW;

  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(N_ROWS - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = {PHASE_W{1'b1}};

  logic               w_tick;
  logic               w_row_end;
  logic               w_boundary;
  logic               w_lit;
  logic [IDX_W-1:0]   w_base;
  logic [N_ROWS-1:0]  w_row_sel;
  logic [N_COLS-1:0]  w_pixels;

  logic [ROW_W-1:0]   r_row;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_bright;
  logic [FRAME_W-1:0] r_active;
  logic [FRAME_W-1:0] r_shadow;
  logic               r_pending;
  logic               r_sync;

  scan_tick_gen #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_tick (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .o_Tick(w_tick)
  );

  assign w_row_end  = w_tick && (r_phase == PHASE_LAST);
  assign w_boundary = w_row_end && (r_row == ROW_LAST);

  // Brightness is latched only at row starts so a row never changes duty mid-dwell.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_row    <= '0;
      r_phase  <= '0;
      r_bright <= '0;
    end else if (w_tick) begin
      r_phase <= r_phase + PHASE_W'(1);
      if (w_row_end) begin
        r_bright <= i_Brightness;
        r_row    <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
      end
    end
  end

  // A frame captured on the boundary cycle itself waits for the next boundary.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_sync    <= 1'b0;
    end else begin
      r_sync <= 1'b0;
      if (w_boundary && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
        r_sync    <= 1'b1;
      end else if (i_Frame_DV && !r_pending) begin
        r_shadow  <= i_Frame_Data;
        r_pending <= 1'b1;
      end
    end
  end

  assign w_base    = IDX_W'(r_row) * IDX_W'(N_COLS);
  assign w_pixels  = r_active[w_base +: N_COLS];
  assign w_row_sel = N_ROWS'(1) << r_row;
  // Phase 0 is a blanking slot, so full brightness still leaves one dark phase per row.
  assign w_lit     = i_Enable && (r_phase != '0) && (r_phase <= r_bright);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_Rows    <= {N_ROWS{~ROW_ON}};
      o_Columns <= {N_COLS{~COL_ON}};
    end else if (w_lit) begin
      o_Rows    <= ROW_ON ? w_row_sel : ~w_row_sel;
      o_Columns <= COL_ON ? w_pixels : ~w_pixels;
    end else begin
      o_Rows    <= {N_ROWS{~ROW_ON}};
      o_Columns <= {N_COLS{~COL_ON}};
    end
  end

  assign o_Frame_Ready = ~r_pending;
  assign o_Frame_Sync  = r_sync;

endmodule
